// File: rtl/axi_wr_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_wr_data_arbiter
//  Purpose  : Round-robin, burst-locked arbiter sharing one AXI3 W channel
//             between NUM_REQ write masters. The grant is held from the first
//             beat until the wlast handshake, so beats are never interleaved.
//  Revision : 1.0  initial release
// ============================================================================
module axi_wr_data_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_MAX_WIDTH = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_BURST    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 s_wvalid,
    output logic [NUM_REQ-1:0]                 s_wready,
    input  logic [NUM_REQ*ID_MAX_WIDTH-1:0]    s_wid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    s_wstrb,
    input  logic [NUM_REQ-1:0]                 s_wlast,
    output logic                               m_wvalid,
    input  logic                               m_wready,
    output logic [ID_MAX_WIDTH-1:0]            m_wid,
    output logic [DATA_WIDTH-1:0]              m_wdata,
    output logic [DATA_WIDTH/8-1:0]            m_wstrb,
    output logic                               m_wlast,
    output logic [NUM_REQ-1:0]                 grant_oh,
    output logic [$clog2(MAX_BURST+1)-1:0]     beat_cnt,
    output logic                               len_err
);

    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W  = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [c_PTR_W-1:0]   r_gidx;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic                 r_len_err;

    logic                 w_pick_found;
    logic [c_PTR_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic                 w_hs;
    int                   w_scan_idx;

    // Round-robin search: first requesting index at or after r_rr_ptr (scan
    // backwards so the lowest offset is the last one written and wins).
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_REQ) begin
                w_scan_idx = w_scan_idx - NUM_REQ;
            end
            if (s_wvalid[c_PTR_W'(w_scan_idx)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = c_PTR_W'(w_scan_idx);
            end
        end
    end

    assign w_pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
    assign w_next_ptr = (r_gidx == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    // AND-OR mux of the granted requester onto the downstream port; an empty
    // grant (IDLE) yields all-zero outputs and no ready to any requester.
    always_comb begin
        m_wvalid = 1'b0;
        m_wid    = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_oh[i]) begin
                m_wvalid = s_wvalid[i];
                m_wid    = s_wid[i*ID_MAX_WIDTH +: ID_MAX_WIDTH];
                m_wdata  = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_wstrb  = s_wstrb[i*c_STRB_W +: c_STRB_W];
                m_wlast  = s_wlast[i];
            end
        end
        s_wready = r_grant_oh & {NUM_REQ{m_wready}};
    end

    assign w_hs = m_wvalid & m_wready;

    // Arbitration FSM: grant on any request in IDLE, hold through wlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_grant_oh <= w_pick_oh;
                        r_gidx     <= w_pick_idx;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_hs) begin
                        // A non-final beat when MAX_BURST-1 beats are already
                        // accepted means the burst is overlong.
                        if ((r_beat_cnt == c_CNT_W'(MAX_BURST - 1)) && !m_wlast) begin
                            r_len_err <= 1'b1;
                        end
                        if (m_wlast) begin
                            r_rr_ptr   <= w_next_ptr;
                            r_beat_cnt <= '0;
                            r_grant_oh <= '0;
                            r_state    <= ST_IDLE;
                        end else if (r_beat_cnt != {c_CNT_W{1'b1}}) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant_oh <= '0;
                end
            endcase
        end
    end

    assign grant_oh = r_grant_oh;
    assign beat_cnt = r_beat_cnt;
    assign len_err  = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_data_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_wr_data_arbiter
//  Purpose  : Self-checking bench for axi_wr_data_arbiter. Requesters are
//             queues of bursts; a transaction-level model predicts grants,
//             forwarded beats, beat count and the sticky length error.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_wr_data_arbiter;

    localparam int c_N  = 4;
    localparam int c_ID = 12;
    localparam int c_DW = 32;
    localparam int c_SW = 4;
    localparam int c_MB = 16;

    typedef struct packed {
        logic [c_ID-1:0] id;
        logic [c_DW-1:0] data;
        logic [c_SW-1:0] strb;
        logic            last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [c_N-1:0]       s_wvalid = '0;
    logic [c_N-1:0]       s_wready;
    logic [c_N*c_ID-1:0]  s_wid = '0;
    logic [c_N*c_DW-1:0]  s_wdata = '0;
    logic [c_N*c_SW-1:0]  s_wstrb = '0;
    logic [c_N-1:0]       s_wlast = '0;
    logic                 m_wvalid;
    logic                 m_wready = 1'b0;
    logic [c_ID-1:0]      m_wid;
    logic [c_DW-1:0]      m_wdata;
    logic [c_SW-1:0]      m_wstrb;
    logic                 m_wlast;
    logic [c_N-1:0]       grant_oh;
    logic [4:0]           beat_cnt;
    logic                 len_err;

    axi_wr_data_arbiter #(
        .NUM_REQ(c_N), .ID_MAX_WIDTH(c_ID), .DATA_WIDTH(c_DW), .MAX_BURST(c_MB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wid(s_wid),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wid(m_wid),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .grant_oh(grant_oh), .beat_cnt(beat_cnt), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Requester side
    beat_t q [c_N][$];
    bit    pres [c_N];
    bit    force_all = 1'b0;
    int    vprob = 100;
    int    rmode = 0;
    bit    tog = 1'b0;

    // Reference model state
    bit    mdl_busy = 1'b0;
    int    mdl_g = 0;
    int    mdl_ptr = 0;
    int    mdl_cnt = 0;
    bit    mdl_err = 1'b0;
    int    mdl_hs = 0;
    int    dut_hs = 0;

    logic [c_N-1:0] gseq [$];
    logic [c_N-1:0] t3_exp [5];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int r, input int len, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.id   = c_ID'(r * 256 + len);
            b.data = base + 32'(k);
            b.strb = c_SW'($urandom);
            b.last = (k == len - 1);
            q[r].push_back(b);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < c_N; i++) begin
            q[i].delete();
            pres[i] = 1'b0;
        end
    endtask

    // Present head beats; once a beat is offered it is held until accepted.
    task automatic drive();
        beat_t hd;
        for (int i = 0; i < c_N; i++) begin
            if (q[i].size() > 0) begin
                if (!pres[i] && ($urandom_range(0, 99) < vprob)) pres[i] = 1'b1;
                hd = q[i][0];
                s_wvalid[i]            = pres[i];
                s_wid[i*c_ID +: c_ID]  = hd.id;
                s_wdata[i*c_DW +: c_DW] = hd.data;
                s_wstrb[i*c_SW +: c_SW] = hd.strb;
                s_wlast[i]             = hd.last;
            end else begin
                pres[i]                = 1'b0;
                s_wvalid[i]            = force_all;
                s_wid[i*c_ID +: c_ID]  = '0;
                s_wdata[i*c_DW +: c_DW] = '0;
                s_wstrb[i*c_SW +: c_SW] = '0;
                s_wlast[i]             = 1'b0;
            end
        end
        case (rmode)
            0:       m_wready = 1'b1;
            1:       m_wready = ($urandom_range(0, 99) < 70);
            default: begin tog = ~tog; m_wready = tog; end
        endcase
    endtask

    // One clock: drive at negedge, check after settling, advance model at posedge.
    task automatic cycle();
        logic [c_N-1:0] exp_g;
        logic [c_N-1:0] exp_rdy;
        logic           exp_mv;
        bit             found;
        int             idx;
        beat_t          hd;
        drive();
        #1;
        exp_g   = mdl_busy ? (c_N'(1) << mdl_g) : '0;
        exp_mv  = mdl_busy ? s_wvalid[mdl_g] : 1'b0;
        exp_rdy = mdl_busy ? (c_N'(m_wready) << mdl_g) : '0;
        chk("grant_oh", 64'(grant_oh), 64'(exp_g));
        chk("beat_cnt", 64'(beat_cnt), 64'(mdl_cnt));
        chk("len_err",  64'(len_err),  64'(mdl_err));
        chk("m_wvalid", 64'(m_wvalid), 64'(exp_mv));
        chk("s_wready", 64'(s_wready), 64'(exp_rdy));
        if (exp_mv) begin
            chk("m_wid",   64'(m_wid),   64'(s_wid[mdl_g*c_ID +: c_ID]));
            chk("m_wdata", 64'(m_wdata), 64'(s_wdata[mdl_g*c_DW +: c_DW]));
            chk("m_wstrb", 64'(m_wstrb), 64'(s_wstrb[mdl_g*c_SW +: c_SW]));
            chk("m_wlast", 64'(m_wlast), 64'(s_wlast[mdl_g]));
        end
        if (m_wvalid && m_wready) dut_hs++;
        @(posedge clk);
        if (rst) begin
            mdl_busy = 1'b0; mdl_ptr = 0; mdl_cnt = 0; mdl_err = 1'b0;
        end else if (!mdl_busy) begin
            found = 1'b0;
            for (int k = 0; k < c_N; k++) begin
                idx = (mdl_ptr + k) % c_N;
                if (!found && s_wvalid[idx]) begin
                    found = 1'b1; mdl_g = idx; mdl_busy = 1'b1;
                end
            end
        end else if (s_wvalid[mdl_g] && m_wready) begin
            hd = q[mdl_g].pop_front();
            pres[mdl_g] = 1'b0;
            mdl_hs++;
            if (mdl_cnt == c_MB - 1 && !hd.last) mdl_err = 1'b1;
            if (mdl_cnt < 31) mdl_cnt++;
            if (hd.last) begin
                mdl_ptr = (mdl_g + 1) % c_N; mdl_cnt = 0; mdl_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Run until every queue is empty and the model is idle, bounded.
    task automatic drain(input string tag, input int budget);
        int  n;
        bit  pending;
        bit  expired;
        logic [c_N-1:0] prev;
        n = 0;
        expired = 1'b0;
        pending = 1'b1;
        while (pending && !expired) begin
            prev = grant_oh;
            cycle();
            if (grant_oh != '0 && prev == '0) gseq.push_back(grant_oh);
            pending = mdl_busy;
            for (int i = 0; i < c_N; i++) if (q[i].size() > 0) pending = 1'b1;
            n++;
            if (n >= budget) expired = pending;
        end
        chk({tag, "_timeout"}, 64'(expired), 64'(0));
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        t3_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        clear_reqs();
        @(posedge clk);
        @(negedge clk);

        // T1: reset held with every requester asserting valid
        force_all = 1'b1;
        cycle();
        cycle();
        chk("t1_m_wvalid", 64'(m_wvalid), 64'(0));
        chk("t1_s_wready", 64'(s_wready), 64'(0));
        chk("t1_grant_oh", 64'(grant_oh), 64'(0));
        force_all = 1'b0;
        rst = 1'b0;

        // T2: single 4-beat burst from requester 1
        vprob = 100; rmode = 0;
        push_burst(1, 4, 32'hA0);
        cycle();
        chk("t2_grant", 64'(grant_oh), 64'(4'b0010));
        drain("t2", 50);
        chk("t2_idle", 64'(grant_oh), 64'(0));

        // T3: all four requesters, back-to-back 2-beat bursts, fresh pointer
        reset_pulse();
        gseq.delete();
        for (int r = 0; r < c_N; r++) begin
            push_burst(r, 2, 32'h3000 + 32'(r * 16));
            push_burst(r, 2, 32'h3100 + 32'(r * 16));
        end
        drain("t3", 200);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t3_order%0d", j),
                64'((gseq.size() > j) ? gseq[j] : 4'b0000), 64'(t3_exp[j]));
        end

        // T4: 8-beat burst on requester 2 under toggling backpressure
        rmode = 2;
        dut_hs = 0; mdl_hs = 0;
        push_burst(2, 8, 32'h4000);
        drain("t4", 100);
        chk("t4_beats", 64'(dut_hs), 64'(8));

        // Randomized traffic: random lengths, gaps and backpressure
        rmode = 1; vprob = 60;
        dut_hs = 0; mdl_hs = 0;
        begin
            int sent;
            sent = 0;
            for (int b = 0; b < 30; b++) begin
                int r, len;
                r   = $urandom_range(0, c_N - 1);
                len = $urandom_range(1, c_MB);
                push_burst(r, len, $urandom);
                sent += len;
            end
            drain("rand", 5000);
            chk("rand_beats", 64'(dut_hs), 64'(sent));
        end

        // T5: 17-beat burst on requester 0, wlast only on the last beat
        rmode = 0; vprob = 100;
        push_burst(0, 17, 32'h5000);
        drain("t5", 100);
        chk("t5_len_err", 64'(len_err), 64'(1));
        chk("t5_released", 64'(grant_oh), 64'(0));

        // T6: reset in the middle of a requester 3 burst
        mdl_hs = 0;
        push_burst(3, 4, 32'h6000);
        begin
            int n;
            n = 0;
            while (mdl_hs < 2 && n < 20) begin
                cycle();
                n++;
            end
            chk("t6_reach_beat2", 64'(mdl_hs), 64'(2));
        end
        rst = 1'b1;
        clear_reqs();
        push_burst(0, 2, 32'h6100);
        push_burst(3, 2, 32'h6200);
        cycle();
        rst = 1'b0;
        chk("t6_idle", 64'(grant_oh), 64'(0));
        chk("t6_len_err_clr", 64'(len_err), 64'(0));
        cycle();
        chk("t6_grant", 64'(grant_oh), 64'(4'b0001));
        drain("t6", 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
